// File: rtl/core_ifetch_pf_if.sv
// core_ifetch_pf_if: bundle of the fetch unit's bus-facing signals.
//   AXI4-Lite read channels : AXI_ARADDR/ARVALID/ARREADY, AXI_RDATA/RRESP/RVALID/RREADY
//   Control redirect        : REDIRECT, REDIRECT_PC
//   Decode handshake        : INSTR_VALID/INSTR_READY, INSTRUCTION, INSTR_PC, INSTR_FAULT
// master = the fetch unit, slave = memory system plus decode stage.
interface core_ifetch_pf_if #(
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32
);
  logic [AXI_AWIDTH-1:0] AXI_ARADDR;
  logic                  AXI_ARVALID;
  logic                  AXI_ARREADY;
  logic [AXI_DWIDTH-1:0] AXI_RDATA;
  logic [1:0]            AXI_RRESP;
  logic                  AXI_RVALID;
  logic                  AXI_RREADY;
  logic                  REDIRECT;
  logic [31:0]           REDIRECT_PC;
  logic                  INSTR_VALID;
  logic                  INSTR_READY;
  logic [31:0]           INSTRUCTION;
  logic [31:0]           INSTR_PC;
  logic                  INSTR_FAULT;

  modport master (
    output AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    input  AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID,
    input  REDIRECT, REDIRECT_PC,
    output INSTR_VALID, INSTRUCTION, INSTR_PC, INSTR_FAULT,
    input  INSTR_READY
  );

  modport slave (
    input  AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    output AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID,
    output REDIRECT, REDIRECT_PC,
    input  INSTR_VALID, INSTRUCTION, INSTR_PC, INSTR_FAULT,
    output INSTR_READY
  );
endinterface

// File: rtl/core_ifetch_pf.sv
// core_ifetch_pf: prefetching RV32I instruction-fetch unit.
// Issues sequential AXI4-Lite reads ahead of decode (up to MAX_OUTSTANDING in
// flight), buffers responses in a DEPTH-entry in-order FIFO and presents them
// over a valid/ready interface. REDIRECT flushes the FIFO and discards stale
// in-flight responses.
// Ports:
//   CLK  - clock
//   NRST - asynchronous active-low reset
//   bus  - core_ifetch_pf_if.master (AXI AR/R channels, redirect, decode side)
// Optional build macro: IFETCH_FAULT_EN - error responses become faulting NOP
// entries with INSTR_FAULT = 1; otherwise RRESP is ignored.
module core_ifetch_pf #(
  parameter logic [31:0] PC_INIT         = 32'h0,
  parameter int unsigned AXI_AWIDTH      = 32,
  parameter int unsigned AXI_DWIDTH      = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic              CLK,
  input logic              NRST,
  core_ifetch_pf_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;
  typedef logic [PW-1:0] ptr_t;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam sum_t        DEPTH_X = sum_t'(DEPTH);
  localparam sum_t        MAXO_X  = sum_t'(MAX_OUTSTANDING);
  localparam sum_t        DSAT_X  = sum_t'(MAX_OUTSTANDING + 1);

  logic [31:0] fpc_q, fpc_n, rpc_q, rpc_n, pend_pc_q, pend_pc_n;
  logic        arvalid_q, arvalid_n, rready_q, pend_q, pend_n;
  cnt_t        out_q, out_n, disc_q, disc_n, cnt_q, cnt_n;
  ptr_t        wptr_q, rptr_q;
  sum_t        disc_sum;

  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_pc   [DEPTH];

  logic        ar_hs, ar_held, r_hs, push, pop, fifo_valid, credit;
  logic [31:0] redir_pc, in_data;

  assign ar_hs      = arvalid_q & bus.AXI_ARREADY;
  assign ar_held    = arvalid_q & ~bus.AXI_ARREADY;
  assign r_hs       = bus.AXI_RVALID & rready_q;
  assign fifo_valid = (cnt_q != '0);
  assign pop        = fifo_valid & bus.INSTR_READY & ~bus.REDIRECT;
  assign push       = r_hs & (disc_q == '0) & ~bus.REDIRECT;
  assign redir_pc   = {bus.REDIRECT_PC[31:2], 2'b00};

`ifdef IFETCH_FAULT_EN
  logic in_fault;
  logic mem_fault [DEPTH];
  assign in_fault = (bus.AXI_RRESP != 2'b00);
  assign in_data  = in_fault ? NOP : bus.AXI_RDATA[31:0];
  assign bus.INSTR_FAULT = fifo_valid & mem_fault[rptr_q];
  always_ff @(posedge CLK) begin
    if (push) mem_fault[wptr_q] <= in_fault;
  end
`else
  logic unused_rresp;
  assign unused_rresp    = ^bus.AXI_RRESP;
  assign in_data         = bus.AXI_RDATA[31:0];
  assign bus.INSTR_FAULT = 1'b0;
`endif

  always_comb begin
    fpc_n     = fpc_q;
    rpc_n     = rpc_q;
    pend_n    = pend_q;
    pend_pc_n = pend_pc_q;
    disc_n    = disc_q;
    disc_sum  = '0;
    out_n     = out_q + cnt_t'(ar_hs) - cnt_t'(r_hs);
    if (bus.REDIRECT) begin
      cnt_n     = '0;
      // Everything issued so far (including a held AR) is stale.
      disc_sum  = sum_t'(out_q) + sum_t'(arvalid_q) - sum_t'(r_hs);
      disc_n    = (disc_sum > DSAT_X) ? DSAT_X[CW-1:0] : disc_sum[CW-1:0];
      rpc_n     = redir_pc;
      // A held AR must complete first; its successor takes the new PC.
      pend_n    = ar_held;
      pend_pc_n = redir_pc;
      fpc_n     = ar_held ? fpc_q : redir_pc;
    end else begin
      cnt_n = cnt_q + cnt_t'(push) - cnt_t'(pop);
      if (r_hs && (disc_q != '0)) disc_n = disc_q - cnt_t'(1);
      if (push) rpc_n = rpc_q + 32'd4;
      if (ar_hs) begin
        fpc_n  = pend_q ? pend_pc_q : fpc_q + 32'd4;
        pend_n = 1'b0;
      end
    end
    // Credit uses next-state counts so issue can proceed back-to-back.
    credit    = ((sum_t'(cnt_n) + sum_t'(out_n)) < DEPTH_X) &&
                (sum_t'(out_n) < MAXO_X);
    arvalid_n = ar_held | credit;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      fpc_q     <= PC_INIT;
      rpc_q     <= PC_INIT;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      out_q     <= '0;
      disc_q    <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      fpc_q     <= fpc_n;
      rpc_q     <= rpc_n;
      pend_q    <= pend_n;
      pend_pc_q <= pend_pc_n;
      arvalid_q <= arvalid_n;
      rready_q  <= 1'b1;
      out_q     <= out_n;
      disc_q    <= disc_n;
      cnt_q     <= cnt_n;
      if (bus.REDIRECT) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + ptr_t'(1);
        if (pop)  rptr_q <= rptr_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wptr_q] <= in_data;
      mem_pc[wptr_q]   <= rpc_q;
    end
  end

  assign bus.AXI_ARADDR  = fpc_q[AXI_AWIDTH-1:0];
  assign bus.AXI_ARVALID = arvalid_q;
  assign bus.AXI_RREADY  = rready_q;
  assign bus.INSTR_VALID = fifo_valid;
  assign bus.INSTRUCTION = fifo_valid ? mem_data[rptr_q] : NOP;
  assign bus.INSTR_PC    = mem_pc[rptr_q];
endmodule

// File: tb/tb_core_ifetch_pf.sv
// tb_core_ifetch_pf: directed scoreboard bench for core_ifetch_pf.
// Memory model returns 32'hC0DE0000 | addr[15:0]; address 0x8 answers SLVERR.
module tb_core_ifetch_pf;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic clk;
  logic nrst;
  bit   rhold;
  int   n_chk, n_err, pops, ar_count;

  exp_t        exp_in[$];
  logic [31:0] exp_ar[$];
  logic [31:0] rq[$];

  core_ifetch_pf_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) bus ();

  core_ifetch_pf #(
    .PC_INIT(32'h0), .AXI_AWIDTH(32), .AXI_DWIDTH(32),
    .DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .CLK(clk), .NRST(nrst), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc = pc; e.instr = instr; e.fault = fault;
    exp_in.push_back(e);
  endtask

  // Memory slave: R data one cycle after the AR handshake, in order.
  initial begin
    bus.AXI_RVALID = 1'b0;
    bus.AXI_RDATA  = '0;
    bus.AXI_RRESP  = 2'b00;
    forever begin
      logic [31:0] a;
      @(posedge clk);
      if (!nrst) rq.delete();
      else begin
        if (bus.AXI_RVALID && bus.AXI_RREADY && rq.size() > 0) void'(rq.pop_front());
        if (bus.AXI_ARVALID && bus.AXI_ARREADY) rq.push_back(bus.AXI_ARADDR);
      end
      #2;
      if (!rhold && rq.size() > 0) begin
        a = rq[0];
        bus.AXI_RVALID = 1'b1;
        bus.AXI_RDATA  = 32'hC0DE0000 | {16'h0, a[15:0]};
        bus.AXI_RRESP  = (a == 32'h8) ? 2'b10 : 2'b00;
      end else begin
        bus.AXI_RVALID = 1'b0;
        bus.AXI_RDATA  = '0;
        bus.AXI_RRESP  = 2'b00;
      end
    end
  end

  // Monitor: handshakes that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.AXI_ARVALID && bus.AXI_ARREADY) begin
        ar_count++;
        if (exp_ar.size() > 0) check("araddr", bus.AXI_ARADDR, exp_ar.pop_front());
      end
      if (bus.INSTR_VALID && bus.INSTR_READY && !bus.REDIRECT) begin
        pops++;
        if (exp_in.size() == 0) check("unexpected_pop_pc", bus.INSTR_PC, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_in.pop_front();
          check("instr_pc", bus.INSTR_PC, e.pc);
          check("instruction", bus.INSTRUCTION, e.instr);
          check("instr_fault", 32'(bus.INSTR_FAULT), 32'(e.fault));
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_arvalid"}, 32'(bus.AXI_ARVALID), 32'd0);
    check({tag, "_rready"}, 32'(bus.AXI_RREADY), 32'd0);
    check({tag, "_instr_valid"}, 32'(bus.INSTR_VALID), 32'd0);
    check({tag, "_instruction"}, bus.INSTRUCTION, NOP);
    check({tag, "_instr_fault"}, 32'(bus.INSTR_FAULT), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    nrst = 1'b0;
    bus.REDIRECT = 1'b0;
    bus.INSTR_READY = 1'b0;
    rhold = 1'b0;
    exp_ar.delete();
    exp_in.delete();
    ar_count = 0;
    #1;
    reset_checks(tag);
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
  endtask

  task automatic drain(input int n, input bit nobubble);
    int target, bubbles;
    bit done;
    target = pops + n;
    bubbles = 0;
    done = 1'b0;
    bus.INSTR_READY = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (pops >= target) done = 1'b1;
      else if (nobubble && pops > target - n && !bus.INSTR_VALID) bubbles++;
    end
    bus.INSTR_READY = 1'b0;
    check("drain_complete", 32'(done), 32'd1);
    if (nobubble) check("stream_bubbles", 32'(bubbles), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    n_chk = 0; n_err = 0; pops = 0; ar_count = 0;
    nrst = 1'b1;
    bus.AXI_ARREADY = 1'b0;
    bus.INSTR_READY = 1'b0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = '0;
    rhold = 1'b0;
    #1;
    do_reset("reset");

    // Streaming with fault at 0x8.
    for (int i = 0; i < 8; i++) exp_ar.push_back(32'(i * 4));
    push_exp(32'h00, 32'hC0DE0000, 1'b0);
    push_exp(32'h04, 32'hC0DE0004, 1'b0);
`ifdef IFETCH_FAULT_EN
    push_exp(32'h08, NOP, 1'b1);
`else
    push_exp(32'h08, 32'hC0DE0008, 1'b0);
`endif
    push_exp(32'h0C, 32'hC0DE000C, 1'b0);
    push_exp(32'h10, 32'hC0DE0010, 1'b0);
    push_exp(32'h14, 32'hC0DE0014, 1'b0);
    push_exp(32'h18, 32'hC0DE0018, 1'b0);
    push_exp(32'h1C, 32'hC0DE001C, 1'b0);
    bus.AXI_ARREADY = 1'b1;
    @(posedge clk); #1;
    check("rready_after_reset", 32'(bus.AXI_RREADY), 32'd1);
    drain(8, 1'b1);
    check("stream_ar_consumed", 32'(exp_ar.size()), 32'd0);

    // Mid-burst asynchronous reset.
    #2;
    do_reset("midburst_reset");

    // Backpressure: decode stalled, DEPTH reads then stop.
    bus.AXI_ARREADY = 1'b1;
    for (int i = 0; i < 5; i++) exp_ar.push_back(32'(i * 4));
    push_exp(32'h00, 32'hC0DE0000, 1'b0);
    push_exp(32'h04, 32'hC0DE0004, 1'b0);
`ifdef IFETCH_FAULT_EN
    push_exp(32'h08, NOP, 1'b1);
`else
    push_exp(32'h08, 32'hC0DE0008, 1'b0);
`endif
    push_exp(32'h0C, 32'hC0DE000C, 1'b0);
    push_exp(32'h10, 32'hC0DE0010, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("bp_ar_count", 32'(ar_count), 32'd4);
    check("bp_arvalid", 32'(bus.AXI_ARVALID), 32'd0);
    check("bp_rready", 32'(bus.AXI_RREADY), 32'd1);
    check("bp_instr_valid", 32'(bus.INSTR_VALID), 32'd1);
    check("bp_head_instr", bus.INSTRUCTION, 32'hC0DE0000);
    check("bp_head_pc", bus.INSTR_PC, 32'h0);
    drain(5, 1'b0);
    check("bp_ar_consumed", 32'(exp_ar.size()), 32'd0);

    // Redirect with two reads outstanding.
    #2;
    do_reset("redir1_reset");
    rhold = 1'b1;
    bus.AXI_ARREADY = 1'b1;
    exp_ar.push_back(32'h0);
    exp_ar.push_back(32'h4);
    exp_ar.push_back(32'h200);
    repeat (6) @(posedge clk);
    #1;
    check("redir1_outstanding", 32'(ar_count), 32'd2);
    check("redir1_arvalid_capped", 32'(bus.AXI_ARVALID), 32'd0);
    exp_in.delete();
    push_exp(32'h200, 32'hC0DE0200, 1'b0);
    push_exp(32'h204, 32'hC0DE0204, 1'b0);
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'h202;
    @(posedge clk); #1;
    bus.REDIRECT = 1'b0;
    rhold = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("redir1_stale_dropped", 32'(bus.INSTR_VALID), 32'd0);
    drain(2, 1'b0);
    check("redir1_ar_consumed", 32'(exp_ar.size()), 32'd0);

    // Redirect while an AR is held by ARREADY = 0.
    #2;
    do_reset("redir2_reset");
    bus.AXI_ARREADY = 1'b0;
    exp_ar.push_back(32'h0);
    exp_ar.push_back(32'h300);
    exp_ar.push_back(32'h304);
    push_exp(32'h300, 32'hC0DE0300, 1'b0);
    push_exp(32'h304, 32'hC0DE0304, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.AXI_ARVALID) seen = 1'b1;
    end
    check("redir2_arvalid_rise", 32'(seen), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("redir2_held_araddr", bus.AXI_ARADDR, 32'h0);
      check("redir2_held_arvalid", 32'(bus.AXI_ARVALID), 32'd1);
      if (i == 0) begin
        bus.REDIRECT = 1'b1;
        bus.REDIRECT_PC = 32'h300;
      end
      @(posedge clk); #1;
      bus.REDIRECT = 1'b0;
    end
    bus.AXI_ARREADY = 1'b1;
    drain(2, 1'b0);
    check("redir2_ar_consumed", 32'(exp_ar.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/core_ifetch_pf.md
Name: core_ifetch_pf

Overview:
- Parametrised prefetching instruction-fetch unit for the RV32I pipeline.
- AXI4-Lite read master that issues sequential fetches ahead of decode. Up to MAX_OUTSTANDING reads can be in flight.
- Fetched words are buffered in a DEPTH-entry in-order FIFO and presented to decode over a valid/ready interface.
- Control redirects (branch, jump, trap) flush the buffer and discard stale in-flight responses.

Parameters:
- PC_INIT, 32'h0, fetch address after reset.
- AXI_AWIDTH, 32, AR address width; ARADDR = FPC[AXI_AWIDTH-1:0].
- AXI_DWIDTH, 32, R data width; the instruction is RDATA[31:0].
- DEPTH, 4, prefetch FIFO entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered ARs; 1..DEPTH.

Ports:
- CLK  in  1  clock
- NRST  in  1  asynchronous active-low reset
- AXI_ARADDR  out  AXI_AWIDTH  fetch address
- AXI_ARVALID  out  1  address valid
- AXI_ARREADY  in  1  address ready
- AXI_RDATA  in  AXI_DWIDTH  read data
- AXI_RRESP  in  2  read response
- AXI_RVALID  in  1  read data valid
- AXI_RREADY  out  1  read ready
- REDIRECT  in  1  flush and restart fetch at REDIRECT_PC
- REDIRECT_PC  in  32  new fetch address; bits [1:0] ignored (forced 0)
- INSTR_VALID  out  1  FIFO head valid
- INSTR_READY  in  1  decode accepts head
- INSTRUCTION  out  32  head instruction; 32'h00000013 when FIFO empty
- INSTR_PC  out  32  address of head instruction
- INSTR_FAULT  out  1  head came from an error response

Behaviour:
- Reset (NRST low, asynchronous):
  - FPC = PC_INIT; FIFO empty; outstanding = 0; discard = 0.
  - ARVALID = 0; RREADY = 0; INSTR_VALID = 0; INSTRUCTION = 32'h00000013; INSTR_FAULT = 0.
- RREADY is registered. It is 1 from the first clock after reset release.
- Credit rule: a new AR may be raised only when all of the following hold:
  - fifo_count + outstanding + ARVALID < DEPTH;
  - outstanding < MAX_OUTSTANDING;
  - not REDIRECT this cycle.
  - Because space is always reserved, RREADY never drops.
- AR channel:
  - ARVALID is registered. ARADDR = FPC and is stable while ARVALID = 1 and ARREADY = 0.
  - ARVALID is never withdrawn before the handshake, including on REDIRECT.
  - On ARVALID & ARREADY: outstanding +1, FPC += 4 (32-bit wrap). ARVALID re-asserts the next cycle only if credit remains.
  - Back-to-back issue (one AR per cycle) is supported.
- R channel:
  - On RVALID & RREADY: outstanding -1.
  - If discard > 0: discard -1 and the data is dropped.
  - Otherwise push {RDATA, pc_of_response, fault} to the FIFO. pc_of_response comes from an issue-PC shadow queue (depth MAX_OUTSTANDING), or equivalently from a response-PC counter.
  - Responses are in order; no IDs.
- FIFO:
  - Pop on INSTR_VALID & INSTR_READY.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Zero-bubble streaming: with ARREADY = 1 and RVALID one cycle after AR, decode sees one instruction per cycle once primed.
- REDIRECT (single cycle, highest priority):
  - FIFO cleared; any same-cycle pop or push is ignored.
  - The next AR uses REDIRECT_PC: FPC <= REDIRECT_PC, unless an AR is held pending. In that case the held AR is completed first and FPC is loaded with REDIRECT_PC after its handshake.
  - discard <= outstanding + (AR handshake this cycle) + (pending unaccepted ARVALID) - (R handshake this cycle).
  - The held pending AR is treated as stale.
  - Back-to-back REDIRECTs accumulate correctly. Discard saturates at MAX_OUTSTANDING + 1.
- Latency: REDIRECT at cycle N with an idle bus gives ARVALID at N+1. With single-cycle ARREADY and RVALID at N+2, INSTR_VALID is at N+3.
- Counter widths: $clog2(DEPTH+1) bits. The FIFO pointer wraps modulo DEPTH.

Optional Feature:
- Macro: IFETCH_FAULT_EN.
- Defined:
  - RRESP != 2'b00 pushes an entry with INSTR_FAULT = 1 and INSTRUCTION = 32'h00000013.
  - Fetch continues sequentially.
  - Decode raises the instruction-access-fault trap via REDIRECT.
- Undefined:
  - RRESP is ignored and RDATA is pushed as-is.
  - INSTR_FAULT is tied to 0.

Test Plan:
- Reset: hold NRST low mid-burst with ARVALID = 1.
  - All outputs take their reset values immediately, without a clock.
  - After release, the first ARADDR is PC_INIT = 0x0.
- Streaming: ARREADY = 1, RVALID one cycle later, INSTR_READY = 1.
  - ARADDR sequence is 0x0, 0x4, 0x8, ...
  - INSTR_PC matches each RDATA.
  - INSTR_VALID stays high continuously once primed.
- Backpressure: INSTR_READY = 0, DEPTH = 4.
  - Exactly 4 ARs are issued, then ARVALID = 0 and RREADY stays 1.
  - On release, 4 pops in order, then fetch resumes at 0x10.
- Redirect with 2 outstanding to 0x200:
  - Both stale responses are dropped; the FIFO is empty.
  - The next INSTR_PC = 0x200 with matching data.
- Redirect to 0x300 while ARVALID is held, ARREADY = 0 for 3 cycles:
  - ARADDR stays stable.
  - Its response is discarded.
  - The following AR is 0x300.
- RRESP = 2'b10 at address 0x8:
  - With IFETCH_FAULT_EN: INSTR_FAULT = 1, INSTRUCTION = 0x00000013.
  - Without: raw RDATA is delivered and INSTR_FAULT = 0.
